mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, meaning SRAM access cycles counted in ACCESS before R is asserted (legal 1..15).
REQ-002 SHALL have parameter IO_ADDR, default 16'hFFFF, meaning the memory-mapped I/O address for switches and hex display.
REQ-003 SHALL have ports:
  Clk  in  1  single system clock, all state on rising edge
  Reset_n  in  1  asynchronous, active-low reset
  ADDR  in  16  access address (from MAR)
  Data_from_CPU  in  16  write data (from MDR)
  MEM_rd_req  in  1  read request, held by CPU until R seen
  MEM_wr_req  in  1  write request, held by CPU until R seen
  R  out  1  ready, one-cycle pulse completing an access
  Data_to_CPU  out  16  read data, held until next read completes
  SRAM_ADDR  out  16  SRAM address
  Data_to_SRAM  out  16  SRAM write data
  Data_from_SRAM  in  16  SRAM read data
  SRAM_CE_n, SRAM_OE_n, SRAM_WE_n  out  1 each  active-low SRAM strobes
  SW  in  10  board switches, asynchronous to Clk
  HEX_data  out  16  hex display register

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, DONE, RELEASE.
REQ-005 IDLE -> ACCESS when MEM_rd_req or MEM_wr_req is 1; ADDR and Data_from_CPU captured at that edge; request type captured at that edge.
REQ-006 MEM_rd_req and MEM_wr_req both 1 in IDLE SHALL be treated as a read; write ignored.
REQ-007 ACCESS to SRAM address SHALL last exactly WAIT_STATES cycles (4-bit counter), then -> DONE.
REQ-008 ACCESS to IO_ADDR SHALL last exactly 1 cycle regardless of WAIT_STATES, then -> DONE; SRAM_CE_n stays 1.
REQ-009 During SRAM ACCESS: SRAM_CE_n=0; read -> SRAM_OE_n=0, SRAM_WE_n=1; write -> SRAM_WE_n=0, SRAM_OE_n=1; SRAM_ADDR/Data_to_SRAM = captured values.
REQ-010 Read data SHALL load Data_to_CPU on the last ACCESS cycle edge: Data_from_SRAM, or {6'b0, synchronized SW} for IO_ADDR.
REQ-011 Write to IO_ADDR SHALL load HEX_data with captured Data_from_CPU on the last ACCESS cycle edge; no SRAM strobe.
REQ-012 R SHALL be 1 only in DONE (exactly one cycle); DONE -> RELEASE unconditionally.
REQ-013 RELEASE -> IDLE only when MEM_rd_req and MEM_wr_req are both 0; a held request SHALL NOT start a second access.
REQ-014 Request deassertion during ACCESS SHALL NOT abort the access; it completes and R pulses.
REQ-015 Outside ACCESS all SRAM strobes SHALL be 1.
REQ-016 Total latency, request-in-IDLE edge to R=1: WAIT_STATES+1 cycles SRAM, 2 cycles I/O.

Reset
REQ-017 Reset_n=0 SHALL immediately, without Clk, force state IDLE, R=0, counter=0, Data_to_CPU=0, HEX_data=0, SRAM_ADDR=0, Data_to_SRAM=0, SW synchronizer=0, all SRAM strobes=1.
REQ-018 Reset mid-access SHALL abandon it with no R pulse and no HEX_data update; after release, FSM restarts from IDLE.

Configuration
REQ-019 Macro IO_SYNC_EN defined: SW SHALL pass through a two-flop synchronizer (2-cycle latency) before use.
REQ-020 IO_SYNC_EN undefined: SW SHALL be used directly (zero latency); all other behaviour identical.

Verification
REQ-021 Reset: Reset_n=0 asynchronously mid-cycle -> outputs at REQ-017 values before next Clk edge.
REQ-022 SRAM read: ADDR=16'h0031, MEM_rd_req=1, Data_from_SRAM=16'h1234, WAIT_STATES=2 -> SRAM_OE_n=0 two cycles, R at cycle 3, Data_to_CPU=16'h1234.
REQ-023 I/O read: SW=10'h006 held 3+ cycles, rd at 16'hFFFF -> R at cycle 2, Data_to_CPU=16'h0006, SRAM_CE_n stays 1.
REQ-024 I/O write: wr at 16'hFFFF, Data_from_CPU=16'hBEEF -> HEX_data=16'hBEEF, SRAM_WE_n stays 1.
REQ-025 Held request: MEM_wr_req held 10 cycles at 16'h0040 -> exactly one R pulse, one SRAM_WE_n burst; new access only after deassert.
REQ-026 Both requests plus mid-access reset: rd=wr=1 at 16'h0002 -> read only; repeat with Reset_n=0 in ACCESS -> no R, HEX_data=0.

Source files
------------

// File: rtl/mem_io_responder.sv
// CPU-side memory responder: SRAM accesses with fixed wait states, plus one memory-mapped I/O word.
// Optional macro IO_SYNC_EN adds a two-flop synchronizer on SW; without it SW is sampled directly.
module mem_io_responder #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic        MEM_rd_req,
    input  logic        MEM_wr_req,
    output logic        R,
    output logic [15:0] Data_to_CPU,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        SRAM_CE_n,
    output logic        SRAM_OE_n,
    output logic        SRAM_WE_n,
    input  logic [9:0]  SW,
    output logic [15:0] HEX_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        is_rd;
    logic        is_io;
    logic        last;
    logic [9:0]  sw_use;

`ifdef IO_SYNC_EN
    logic [9:0] sw_meta;
    logic [9:0] sw_sync;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    assign sw_use = sw_sync;
`else
    assign sw_use = SW;
`endif

    // I/O accesses always finish after a single ACCESS cycle.
    assign last = is_io || (cnt == LAST_CNT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            is_rd        <= 1'b0;
            is_io        <= 1'b0;
            R            <= 1'b0;
            Data_to_CPU  <= '0;
            HEX_data     <= '0;
            SRAM_ADDR    <= '0;
            Data_to_SRAM <= '0;
            SRAM_CE_n    <= 1'b1;
            SRAM_OE_n    <= 1'b1;
            SRAM_WE_n    <= 1'b1;
        end else begin
            R <= 1'b0;
            case (state)
                IDLE: begin
                    if (MEM_rd_req || MEM_wr_req) begin
                        state        <= ACCESS;
                        cnt          <= '0;
                        is_rd        <= MEM_rd_req;
                        is_io        <= (ADDR == IO_ADDR);
                        SRAM_ADDR    <= ADDR;
                        Data_to_SRAM <= Data_from_CPU;
                        // Strobes are registered, so they go active on the same edge as ACCESS.
                        if (ADDR != IO_ADDR) begin
                            SRAM_CE_n <= 1'b0;
                            SRAM_OE_n <= !MEM_rd_req;
                            SRAM_WE_n <= MEM_rd_req;
                        end
                    end
                end
                ACCESS: begin
                    if (last) begin
                        state     <= DONE;
                        R         <= 1'b1;
                        cnt       <= '0;
                        SRAM_CE_n <= 1'b1;
                        SRAM_OE_n <= 1'b1;
                        SRAM_WE_n <= 1'b1;
                        if (is_rd)
                            Data_to_CPU <= is_io ? {6'b0, sw_use} : Data_from_SRAM;
                        else if (is_io)
                            HEX_data <= Data_to_SRAM;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: state <= RELEASE;
                RELEASE: begin
                    // Wait for the CPU to drop its request so a held request is not replayed.
                    if (!MEM_rd_req && !MEM_wr_req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder: a transaction-level model predicts every output each cycle,
// and directed cases pin latency, data and reset behaviour with literal expectations.
module tb_mem_io_responder;

    localparam int          WS  = 2;
    localparam logic [15:0] IOA = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] ADDR = '0;
    logic [15:0] Data_from_CPU = '0;
    logic        MEM_rd_req = 1'b0;
    logic        MEM_wr_req = 1'b0;
    logic        R;
    logic [15:0] Data_to_CPU;
    logic [15:0] SRAM_ADDR;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM = '0;
    logic        SRAM_CE_n, SRAM_OE_n, SRAM_WE_n;
    logic [9:0]  SW = '0;
    logic [15:0] HEX_data;

    mem_io_responder #(.WAIT_STATES(WS), .IO_ADDR(IOA)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .MEM_rd_req(MEM_rd_req), .MEM_wr_req(MEM_wr_req), .R(R), .Data_to_CPU(Data_to_CPU),
        .SRAM_ADDR(SRAM_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .SRAM_CE_n(SRAM_CE_n), .SRAM_OE_n(SRAM_OE_n), .SRAM_WE_n(SRAM_WE_n),
        .SW(SW), .HEX_data(HEX_data)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request occupies lat cycles until R, then the
    // responder waits for the request lines to drop before accepting again.
    bit          m_busy = 0;
    int          m_n = 0, m_lat = 0;
    bit          m_rd = 0, m_io = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_dout = '0, m_hex = '0;

    initial forever begin
        @(posedge Clk or negedge Reset_n);
        if (!Reset_n) begin
            m_busy = 0; m_n = 0; m_dout = '0; m_hex = '0;
        end else if (!m_busy) begin
            if (MEM_rd_req || MEM_wr_req) begin
                m_busy  = 1;
                m_n     = 0;
                m_rd    = MEM_rd_req;
                m_addr  = ADDR;
                m_wdata = Data_from_CPU;
                m_io    = (ADDR == IOA);
                m_lat   = m_io ? 2 : WS + 1;
            end
        end else begin
            m_n++;
            if (m_n == m_lat - 1) begin
                if (m_rd) m_dout = m_io ? {6'b0, SW} : Data_from_SRAM;
                else if (m_io) m_hex = m_wdata;
            end
            if (m_n > m_lat && !MEM_rd_req && !MEM_wr_req) m_busy = 0;
        end
    end

    // Per-cycle comparison plus strobe activity counters used by the directed cases.
    bit chk_en = 0;
    bit e_acc, e_r;
    int r_cnt = 0, oe_low = 0, ce_low = 0, we_low = 0, we_bursts = 0;
    logic we_prev = 1'b1;

    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            e_acc = m_busy && (m_n <= m_lat - 2);
            e_r   = m_busy && (m_n == m_lat - 1);
            chk("R", R, e_r);
            chk("SRAM_CE_n", SRAM_CE_n, !(e_acc && !m_io));
            chk("SRAM_OE_n", SRAM_OE_n, !(e_acc && !m_io && m_rd));
            chk("SRAM_WE_n", SRAM_WE_n, !(e_acc && !m_io && !m_rd));
            chk("Data_to_CPU", Data_to_CPU, m_dout);
            chk("HEX_data", HEX_data, m_hex);
            if (e_acc && !m_io) begin
                chk("SRAM_ADDR", SRAM_ADDR, m_addr);
                if (!m_rd) chk("Data_to_SRAM", Data_to_SRAM, m_wdata);
            end
            r_cnt  += int'(R);
            oe_low += int'(!SRAM_OE_n);
            ce_low += int'(!SRAM_CE_n);
            we_low += int'(!SRAM_WE_n);
            if (we_prev && !SRAM_WE_n) we_bursts++;
            we_prev = SRAM_WE_n;
        end
    end

    bit          fixed_sram = 0;
    logic [15:0] fixed_val = '0;
    initial forever begin
        @(negedge Clk);
        Data_from_SRAM = fixed_sram ? fixed_val : 16'($urandom);
    end

    // Issues one access, waits (bounded) for R, holds the request, then idles long enough
    // for the responder to see both request lines low.
    task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input int hold, input bit drop, output int lat);
        bit got;
        @(negedge Clk);
        MEM_rd_req = rd; MEM_wr_req = wr; ADDR = a; Data_from_CPU = d;
        lat = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            lat++;
            if (drop) begin MEM_rd_req = 0; MEM_wr_req = 0; end
            if (R) got = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL r_timeout: got no R within 40 cycles, expected R (addr %0h)", a);
        end
        repeat (hold) @(negedge Clk);
        MEM_rd_req = 0; MEM_wr_req = 0;
        @(negedge Clk);
        #1;
    endtask

    int lat, r0, oe0, ce0, we0, wb0;

    task automatic snap();
        r0 = r_cnt; oe0 = oe_low; ce0 = ce_low; we0 = we_low; wb0 = we_bursts;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_R"}, R, 1'b0);
        chk({tag, "_Data_to_CPU"}, Data_to_CPU, 16'h0);
        chk({tag, "_HEX_data"}, HEX_data, 16'h0);
        chk({tag, "_SRAM_ADDR"}, SRAM_ADDR, 16'h0);
        chk({tag, "_Data_to_SRAM"}, Data_to_SRAM, 16'h0);
        chk({tag, "_strobes"}, {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n}, 3'b111);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd, wr, io;
        logic [15:0] a;
        Reset_n = 1'b0;
        chk_en  = 1;
        repeat (3) @(negedge Clk);
        #1 check_reset_outputs("por");
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // SRAM read, WAIT_STATES=2
        fixed_sram = 1; fixed_val = 16'h1234;
        snap();
        access(1, 0, 16'h0031, 16'h0, 0, 0, lat);
        chk("sram_rd_latency", lat, 3);
        chk("sram_rd_data", Data_to_CPU, 16'h1234);
        chk("sram_rd_oe_cycles", oe_low - oe0, 2);
        fixed_sram = 0;

        // I/O read of switches
        SW = 10'h006;
        repeat (4) @(negedge Clk);
        #1 snap();
        access(1, 0, 16'hFFFF, 16'h0, 0, 0, lat);
        chk("io_rd_latency", lat, 2);
        chk("io_rd_data", Data_to_CPU, 16'h0006);
        chk("io_rd_ce_cycles", ce_low - ce0, 0);

        // I/O write to hex display
        snap();
        access(0, 1, 16'hFFFF, 16'hBEEF, 0, 0, lat);
        chk("io_wr_latency", lat, 2);
        chk("io_wr_hex", HEX_data, 16'hBEEF);
        chk("io_wr_we_cycles", we_low - we0, 0);

        // Write request held ten cycles
        snap();
        access(0, 1, 16'h0040, 16'h4242, 7, 0, lat);
        chk("held_wr_latency", lat, 3);
        chk("held_wr_r_pulses", r_cnt - r0, 1);
        chk("held_wr_we_bursts", we_bursts - wb0, 1);
        chk("held_wr_we_cycles", we_low - we0, 2);

        // Both requests: treated as a read
        snap();
        access(1, 1, 16'h0002, 16'h5555, 0, 0, lat);
        chk("both_latency", lat, 3);
        chk("both_we_cycles", we_low - we0, 0);
        chk("both_oe_cycles", oe_low - oe0, 2);

        // Reset during an SRAM write access
        snap();
        @(negedge Clk);
        MEM_wr_req = 1; ADDR = 16'h0100; Data_from_CPU = 16'hA5A5;
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        MEM_wr_req = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        #1 chk("midrst_r_pulses", r_cnt - r0, 0);

        // Reset during an I/O write access: hex must not update
        snap();
        @(negedge Clk);
        MEM_wr_req = 1; ADDR = IOA; Data_from_CPU = 16'h1111;
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1 MEM_wr_req = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        #1 chk("iorst_r_pulses", r_cnt - r0, 0);
        chk("iorst_hex", HEX_data, 16'h0);

        // Recovery after reset
        access(0, 1, IOA, 16'hC0DE, 0, 0, lat);
        chk("post_rst_hex", HEX_data, 16'hC0DE);

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                SW = 10'($urandom);
                repeat (4) @(negedge Clk);
            end
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            rd = 1'($urandom);
            wr = !rd || ($urandom_range(0, 3) == 0);
            io = ($urandom_range(0, 3) == 0);
            a  = io ? IOA : 16'($urandom_range(0, 16'hFFFE));
            access(rd, wr, a, 16'($urandom), $urandom_range(0, 3), ($urandom_range(0, 4) == 0), lat);
            chk("rand_latency", lat, io ? 2 : WS + 1);
        end

        repeat (3) @(negedge Clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
